sym_fir_prog: RTL and testbench

- Parametrised, programmable-coefficient, odd-length, linear-phase (symmetric) FIR filter.
- Successor to the fixed 19-tap / 8-bit filter. Generalises tap count, data width, coefficient width and output scaling.
- Adds run-time coefficient loading, an input valid qualifier (sample gaps allowed), output valid, round-half-up, saturation flag and a synchronous flush.
- Sits between the sample source and the output sink in the filter datapath.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_round_sat.sv | 61 ++++++
 rtl/sym_fir_prog.sv | 124 ++++++++++++
 tb/tb_sym_fir_prog.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared helpers for the FIR datapath: width derivation and signed saturation limits.
package fir_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) r++;
        return r;
    endfunction

    // Unique coefficients of an odd-length symmetric filter
    function automatic int unsigned calc_nc(input int unsigned taps);
        return (taps + 1) / 2;
    endfunction

    // Accumulator wide enough that the full symmetric sum can never overflow
    function automatic int unsigned calc_acc_w(input int unsigned d_w, input int unsigned c_w,
                                               input int unsigned taps);
        return d_w + c_w + 1 + clog2(calc_nc(taps));
    endfunction

    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Registered round-half-up, arithmetic shift and signed saturation stage.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int unsigned IN_W  = 21,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned SHIFT = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             sat
);

    localparam int unsigned RW = IN_W + 1;
    localparam logic signed [RW-1:0] RND   = RW'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0] MAX_V = RW'(sat_max(OUT_W));
    localparam logic signed [RW-1:0] MIN_V = RW'(sat_min(OUT_W));

    logic signed [RW-1:0] sum_c;
    logic signed [RW-1:0] r_c;
    logic [OUT_W-1:0]     data_c;
    logic                 sat_c;

    // One guard bit keeps the rounding add exact before the shift
    always_comb begin
        sum_c  = RW'($signed(in_data)) + RND;
        r_c    = sum_c >>> SHIFT;
        data_c = OUT_W'(r_c);
        sat_c  = 1'b0;
        if (r_c > MAX_V) begin
            data_c = OUT_W'(MAX_V);
            sat_c  = 1'b1;
        end else if (r_c < MIN_V) begin
            data_c = OUT_W'(MIN_V);
            sat_c  = 1'b1;
        end
    end

    // Data and flag hold between valid results; clear only kills the valid
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sat       <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= data_c;
                sat      <= sat_c;
            end
        end
    end

endmodule

// File: rtl/sym_fir_prog.sv
// Programmable odd-length symmetric FIR: delay line, pre-add/multiply, adder tree,
// then a shared round/saturate stage. Four-cycle latency, one output per input.
module sym_fir_prog
    import fir_pkg::*;
#(
    parameter int unsigned D_WIDTH   = 8,
    parameter int unsigned C_WIDTH   = 8,
    parameter int unsigned TAPS      = 19,
    parameter int unsigned OUT_SHIFT = 7
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               clear,
    input  logic                               in_valid,
    input  logic [D_WIDTH-1:0]                 xn_data,
    input  logic                               coef_we,
    input  logic [clog2(calc_nc(TAPS))-1:0]    coef_addr,
    input  logic [C_WIDTH-1:0]                 coef_wdata,
    output logic                               out_valid,
    output logic [D_WIDTH-1:0]                 yn_data,
    output logic                               sat
);

    localparam int unsigned NC     = calc_nc(TAPS);
    localparam int unsigned PRE_W  = D_WIDTH + 1;
    localparam int unsigned PROD_W = PRE_W + C_WIDTH;
    localparam int unsigned ACC_W  = calc_acc_w(D_WIDTH, C_WIDTH, TAPS);

    logic signed [D_WIDTH-1:0] dline  [TAPS];
    logic signed [C_WIDTH-1:0] coef   [NC];
    logic signed [PRE_W-1:0]   pre_c  [NC];
    logic signed [PROD_W-1:0]  prod   [NC];
    logic signed [ACC_W-1:0]   term_c [NC];
    logic signed [ACC_W-1:0]   sum_c;
    logic signed [ACC_W-1:0]   acc;
    logic                      v1;
    logic                      v2;
    logic                      v3;

    // Delay line: dline[0] is the newest sample, advances only on in_valid
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < TAPS; i++) dline[i] <= '0;
            v1 <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) dline[i] <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                dline[0] <= $signed(xn_data);
                for (int i = 1; i < TAPS; i++) dline[i] <= dline[i-1];
            end
        end
    end

    // Coefficient bank survives clear; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NC; i++) coef[i] <= '0;
        end else if (coef_we && (32'(coef_addr) < NC)) begin
            coef[coef_addr] <= $signed(coef_wdata);
        end
    end

    // Per-tap pre-add of mirrored samples; the centre tap has no partner
    for (genvar g = 0; g < NC; g++) begin : g_tap
        if (g == NC - 1) begin : g_centre
            assign pre_c[g] = PRE_W'(dline[g]);
        end else begin : g_pair
            assign pre_c[g] = PRE_W'(dline[g]) + PRE_W'(dline[TAPS-1-g]);
        end
        assign term_c[g] = ACC_W'(prod[g]);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NC; i++) prod[i] <= '0;
            v2 <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NC; i++) prod[i] <= '0;
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                for (int i = 0; i < NC; i++) prod[i] <= PROD_W'(pre_c[i]) * PROD_W'(coef[i]);
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NC; i++) sum_c = sum_c + term_c[i];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc <= '0;
            v3  <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            v3  <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2) acc <= sum_c;
        end
    end

    fir_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (D_WIDTH),
        .SHIFT (OUT_SHIFT)
    ) u_round_sat (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .in_valid  (v3),
        .in_data   (acc),
        .out_valid (out_valid),
        .out_data  (yn_data),
        .sat       (sat)
    );

endmodule

// File: tb/tb_sym_fir_prog.sv
// Self-checking bench for sym_fir_prog: per-cycle comparison against a direct-form
// convolution model plus literal expectations for the directed scenarios.
module tb_sym_fir_prog;

    localparam int unsigned D_WIDTH   = 8;
    localparam int unsigned C_WIDTH   = 8;
    localparam int unsigned TAPS      = 19;
    localparam int unsigned OUT_SHIFT = 7;
    localparam int unsigned NC        = (TAPS + 1) / 2;

    logic       clk        = 1'b0;
    logic       n_rst      = 1'b0;
    logic       clear      = 1'b0;
    logic       in_valid   = 1'b0;
    logic [7:0] xn_data    = '0;
    logic       coef_we    = 1'b0;
    logic [3:0] coef_addr  = '0;
    logic [7:0] coef_wdata = '0;
    logic       out_valid;
    logic [7:0] yn_data;
    logic       sat;

    int n_tests = 0;
    int n_fail  = 0;

    sym_fir_prog #(
        .D_WIDTH   (D_WIDTH),
        .C_WIDTH   (C_WIDTH),
        .TAPS      (TAPS),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .xn_data    (xn_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .out_valid  (out_valid),
        .yn_data    (yn_data),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned due;
        int          y;
        bit          s;
    } exp_t;

    int          hist  [TAPS];
    int          mcoef [NC];
    exp_t        eq [$];
    bit          pend   = 1'b0;
    int unsigned cyc_n  = 0;
    bit          exp_v  = 1'b0;
    int          exp_y  = 0;
    bit          exp_s  = 1'b0;
    int          last_y = 0;
    bit          last_s = 1'b0;

    // y[n] = sum_k h[k] x[n-k] with the full mirrored impulse response
    function automatic void model_out(output int y, output bit s);
        longint a;
        longint r;
        a = 0;
        for (int k = 0; k < TAPS; k++)
            a += longint'(mcoef[(k < NC) ? k : TAPS - 1 - k]) * longint'(hist[k]);
        r = (a + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
        s = 1'b1;
        if (r > 127) y = 127;
        else if (r < -128) y = -128;
        else begin
            y = int'(r);
            s = 1'b0;
        end
    endfunction

    always @(posedge clk) begin
        int   y;
        bit   s;
        exp_t e;
        cyc_n++;
        exp_v = 1'b0;
        if (!n_rst) begin
            for (int k = 0; k < TAPS; k++) hist[k] = 0;
            for (int k = 0; k < NC; k++) mcoef[k] = 0;
            eq.delete();
            pend   = 1'b0;
            last_y = 0;
            last_s = 1'b0;
        end else begin
            // a sample accepted last edge is multiplied now, with coefficients as of last edge
            if (clear) eq.delete();
            else if (pend) begin
                model_out(y, s);
                e.due = cyc_n + 2;
                e.y   = y;
                e.s   = s;
                eq.push_back(e);
            end
            if (coef_we && (int'(coef_addr) < NC)) mcoef[coef_addr] = int'($signed(coef_wdata));
            if (clear) begin
                for (int k = 0; k < TAPS; k++) hist[k] = 0;
                pend = 1'b0;
            end else begin
                pend = in_valid;
                if (in_valid) begin
                    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                    hist[0] = int'($signed(xn_data));
                end
            end
            if (eq.size() > 0 && eq[0].due == cyc_n) begin
                exp_v  = 1'b1;
                exp_y  = eq[0].y;
                exp_s  = eq[0].s;
                last_y = exp_y;
                last_s = exp_s;
                void'(eq.pop_front());
            end
        end
    end

    // ---------------- compare + capture ----------------
    int got_y [$];
    int got_s [$];
    int base = 0;

    always @(posedge clk) begin
        #1;
        if (n_rst) begin
            chk("out_valid", longint'(out_valid), longint'(exp_v));
            if (exp_v) begin
                chk("yn_data", longint'($signed(yn_data)), longint'(exp_y));
                chk("sat", longint'(sat), longint'(exp_s));
            end else begin
                chk("yn_hold", longint'($signed(yn_data)), longint'(last_y));
                chk("sat_hold", longint'(sat), longint'(last_s));
            end
            if (out_valid) begin
                got_y.push_back(int'($signed(yn_data)));
                got_s.push_back(int'(sat));
            end
        end
    end

    function automatic int got_count();
        return got_y.size() - base;
    endfunction

    function automatic int gy(input int i);
        return (got_count() > i) ? got_y[base + i] : -999;
    endfunction

    function automatic int gs(input int i);
        return (got_count() > i) ? got_s[base + i] : -999;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input bit iv, input logic [7:0] x, input bit we,
                         input logic [3:0] a, input logic [7:0] wd, input bit clr);
        @(negedge clk);
        in_valid   = iv;
        xn_data    = x;
        coef_we    = we;
        coef_addr  = a;
        coef_wdata = wd;
        clear      = clr;
    endtask

    task automatic feed(input logic [7:0] x);
        drive(1'b1, x, 1'b0, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] v);
        drive(1'b0, 8'd0, 1'b1, a, v, 1'b0);
    endtask

    task automatic do_clear();
        drive(1'b0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1);
    endtask

    task automatic impulse_run();
        base = got_y.size();
        feed(8'h50);
        repeat (24) feed(8'h00);
        idle(8);
    endtask

    task automatic check_impulse(input string tag, input int val);
        int nz;
        nz = 0;
        chk({tag, " count"}, longint'(got_count()), 25);
        chk({tag, " idx9"}, longint'(gy(9)), longint'(val));
        for (int i = 0; i < 25; i++)
            if (i != 9 && gy(i) != 0) nz++;
        chk({tag, " others"}, longint'(nz), 0);
    endtask

    logic [7:0] gap_coef [NC];

    initial begin
        int n_in;
        gap_coef = '{8'h0a, 8'h00, 8'hf2, 8'he8, 8'heb, 8'h00, 8'h25, 8'h50, 8'h72, 8'h7f};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst out_valid", longint'(out_valid), 0);
        chk("rst yn_data", longint'(yn_data), 0);
        chk("rst sat", longint'(sat), 0);
        n_rst = 1'b1;
        idle(2);

        // centre-tap impulse
        wr(4'd9, 8'h40);
        impulse_run();
        check_impulse("impulse", 40);

        // rounding half-up
        do_clear();
        wr(4'd9, 8'h01);
        base = got_y.size();
        feed(8'h40);
        feed(8'hc0);
        feed(8'h3f);
        repeat (12) feed(8'h00);
        idle(8);
        chk("round 0x40", longint'(gy(9)), 1);
        chk("round 0xc0", longint'(gy(10)), 0);
        chk("round 0x3f", longint'(gy(11)), 0);

        // saturation both directions
        do_clear();
        wr(4'd0, 8'h7f);
        wr(4'd9, 8'h7f);
        base = got_y.size();
        repeat (24) feed(8'h7f);
        idle(6);
        chk("sat pos value", longint'(gy(23)), 127);
        chk("sat pos flag", longint'(gs(23)), 1);
        base = got_y.size();
        repeat (24) feed(8'h80);
        idle(6);
        chk("sat neg value", longint'(gy(23)), -128);
        chk("sat neg flag", longint'(gs(23)), 1);

        // gapped random stream with the 19-tap set
        do_clear();
        for (int i = 0; i < NC; i++) wr(4'(i), gap_coef[i]);
        base = got_y.size();
        n_in = 0;
        for (int i = 0; i < 80; i++) begin
            bit v;
            v = ($urandom_range(0, 9) < 6);
            drive(v, 8'($urandom_range(0, 255)), 1'b0, 4'd0, 8'd0, 1'b0);
            if (v) n_in++;
        end
        idle(8);
        chk("gap out count", longint'(got_count()), longint'(n_in));

        // out-of-range writes, then clear with three outputs in flight
        do_clear();
        for (int i = 0; i < NC - 1; i++) wr(4'(i), 8'h00);
        wr(4'd9, 8'h20);
        wr(4'd10, 8'h7f);
        wr(4'd15, 8'h7f);
        base = got_y.size();
        for (int i = 0; i < 10; i++) feed(8'(i * 7 + 3));
        drive(1'b1, 8'h33, 1'b1, 4'd9, 8'h40, 1'b1);
        idle(8);
        chk("clear drops pending", longint'(got_count()), 7);
        impulse_run();
        check_impulse("post-clear impulse", 40);

        // centre rewrite while streaming
        do_clear();
        base = got_y.size();
        for (int i = 0; i < 30; i++) begin
            if (i == 20) drive(1'b1, 8'h50, 1'b1, 4'd9, 8'h20, 1'b0);
            else feed(8'h50);
        end
        idle(8);
        chk("rewrite count", longint'(got_count()), 30);
        chk("rewrite before", longint'(gy(19)), 40);
        chk("rewrite after", longint'(gy(20)), 20);

        // async reset mid-stream wipes coefficients too
        repeat (5) feed(8'h50);
        @(negedge clk);
        in_valid = 1'b0;
        n_rst    = 1'b0;
        #1;
        chk("midrst out_valid", longint'(out_valid), 0);
        chk("midrst yn_data", longint'(yn_data), 0);
        chk("midrst sat", longint'(sat), 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        idle(2);
        impulse_run();
        check_impulse("post-reset impulse", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
